// File: rtl/resolution_text_serializer.sv
// Serializes one glyph row of a per-video-mode text string (e.g. "1920x1080") from an
// external registered ROM into a pixel stream with optional horizontal pixel repeat.
module resolution_text_serializer #(
  parameter int NUM_CHARS  = 10,
  parameter int GLYPH_W    = 8,
  parameter int ROW_ADDR_W = 4,
  parameter int MODE_W     = 2,
  parameter int NUM_MODES  = 3,
  // Derived: leave at its default.
  parameter int ROW_BITS   = NUM_CHARS * GLYPH_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [MODE_W-1:0]            mode_id,
  input  logic [ROW_ADDR_W-1:0]        row,
  input  logic [1:0]                   scale,
  output logic [MODE_W+ROW_ADDR_W-1:0] rom_addr,
  input  logic [ROW_BITS-1:0]          rom_data,
  output logic                         pixel,
  output logic                         pixel_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         mode_err
);

  localparam int BIT_CNT_W = $clog2(ROW_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(ROW_BITS - 1);
  localparam logic [MODE_W:0] MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ROW_BITS-1:0]   shreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [1:0]            rep_cnt;
  logic [1:0]            scale_q;
  logic                  mode_ok_q;
  logic                  mode_ok;
  logic                  last_hold;

  assign mode_ok   = ({1'b0, mode_id} < MODE_LIMIT);
  assign last_hold = (rep_cnt == scale_q) && (bit_cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (last_hold) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == FETCH) || (state == LOAD) || (state == SHIFT);
  assign done = (state == DONE);

  // The ROM address register doubles as the latched {mode,row} of the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr    <= '0;
      scale_q     <= '0;
      mode_ok_q   <= 1'b0;
      mode_err    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      mode_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr  <= {mode_id, row};
            scale_q   <= scale;
            mode_ok_q <= mode_ok;
            mode_err  <= !mode_ok;
          end
        end
        LOAD: begin
          // Unsupported modes still run full timing, just with a blank row.
          shreg       <= mode_ok_q ? rom_data : '0;
          pixel       <= mode_ok_q & rom_data[ROW_BITS-1];
          pixel_valid <= 1'b1;
          bit_cnt     <= '0;
          rep_cnt     <= '0;
        end
        SHIFT: begin
          if (rep_cnt == scale_q) begin
            rep_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              pixel       <= 1'b0;
              pixel_valid <= 1'b0;
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
              pixel   <= shreg[ROW_BITS-2];
            end
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/resolution_text_serializer.md
RESOLUTION_TEXT_SERIALIZER -- requirements
Module: resolution_text_serializer

Interface
REQ-001 Parameter NUM_CHARS, default 10: characters per text row.
REQ-002 Parameter GLYPH_W, default 8: pixels per character row.
REQ-003 Parameter ROW_ADDR_W, default 4: glyph row address width (16 rows).
REQ-004 Parameter MODE_W, default 2: video mode id width.
REQ-005 Parameter NUM_MODES, default 3: supported modes; ids 0..NUM_MODES-1 valid.
REQ-006 Derived ROW_BITS = NUM_CHARS*GLYPH_W (80 default).
REQ-007 One clock; reset is synchronous and active-high; ports named clock and reset.
REQ-008 clock  in  1  rising-edge clock for all state.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 start  in  1  single-cycle request to render one text row.
REQ-011 mode_id  in  MODE_W  video mode selecting the string (1080p/720p/VGA...).
REQ-012 row  in  ROW_ADDR_W  glyph row to render.
REQ-013 scale  in  2  horizontal pixel repeat minus one (0=1x .. 3=4x).
REQ-014 rom_addr  out  MODE_W+ROW_ADDR_W  {mode,row} address to external string ROM.
REQ-015 rom_data  in  ROW_BITS  ROM row data, valid one cycle after rom_addr changes (registered ROM).
REQ-016 pixel  out  1  current pixel, MSB of row first.
REQ-017 pixel_valid  out  1  pixel is meaningful this cycle.
REQ-018 busy  out  1  request in progress.
REQ-019 done  out  1  one-cycle pulse after last pixel.
REQ-020 mode_err  out  1  one-cycle pulse: start accepted with unsupported mode_id.

Function
REQ-021 FSM states IDLE, FETCH, LOAD, SHIFT, DONE.
REQ-022 IDLE: start=1 at edge N -> FETCH; rom_addr <= {mode_id,row}; mode_id, row, scale latched; busy=1 after edge N.
REQ-023 start outside IDLE ignored; mode_id/row/scale changes after acceptance ignored.
REQ-024 FETCH -> LOAD unconditionally at edge N+1.
REQ-025 LOAD -> SHIFT at edge N+2: shift register <= rom_data (or all zero if mode invalid); pixel_valid=1; pixel=loaded MSB.
REQ-026 SHIFT: each bit held scale+1 cycles via 2-bit repeat counter, then shift left one bit; bit counter width clog2(ROW_BITS).
REQ-027 SHIFT lasts exactly ROW_BITS*(scale+1) cycles; after last held cycle -> DONE.
REQ-028 DONE: done=1, busy=0, pixel_valid=0, pixel=0 for one cycle; -> IDLE.
REQ-029 pixel and pixel_valid are registered outputs; pixel=0 whenever pixel_valid=0.
REQ-030 mode_id >= NUM_MODES at acceptance: mode_err=1 the cycle after edge N; full timing still runs with all-zero pixels.
REQ-031 rom_addr holds last issued value until next accepted start.
REQ-032 Bit counter terminal compare uses ROW_BITS-1; no wrap into a second row.

Reset
REQ-033 reset=1 at any edge, including mid-SHIFT: state IDLE; pixel, pixel_valid, busy, done, mode_err = 0; rom_addr = 0; counters and shift register = 0.
REQ-034 reset has priority over start in the same cycle; start accepted on first edge with reset=0.

Verification
REQ-035 Reset: assert reset 2 cycles with start=1 -> all outputs 0, no FETCH entered.
REQ-036 mode 0, row 5, scale 0, rom_data=80'hF0...F0, start at edge 0 -> rom_addr=6'h05 after edge 0; pixel_valid high after edges 2..81 (80 cycles), pattern 1111 0000 repeated; done pulse after edge 82; busy 0 from then.
REQ-037 Same with scale=3 -> each bit held 4 cycles; 320 pixel_valid cycles; done after edge 322.
REQ-038 mode_id=3 (NUM_MODES=3), rom_data all ones -> mode_err pulse after edge 0; 80 cycles pixel_valid with pixel=0; done after edge 82.
REQ-039 start pulse plus mode_id/row change at pixel 10 -> ignored; rom_addr and pixel stream unchanged; single done.
REQ-040 reset at pixel 40 -> next cycle all outputs 0; new start at following edge produces full 80-pixel row normally.
